// File: rtl/pcss_link_pkg.sv
// Shared constants and FSM state type for the chip link rx/tx pair.
package pcss_link_pkg;

    localparam int CHIPDATA_WIDTH = 16;
    localparam int PKT_WIDTH      = 64;
    localparam int BEATS          = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/chip_link_rx_if.sv
// Link-side beat handshake and router-side packet handshake of one link port.
interface chip_link_rx_if #(
    parameter int CHIPDATA_WIDTH = 16,
    parameter int PKT_WIDTH      = 64,
    parameter int ERRCNT_W       = 8
);
    logic [CHIPDATA_WIDTH-1:0] link_data;
    logic                      link_valid;
    logic                      link_par;
    logic                      link_ready;
    logic                      link_err;
    logic [PKT_WIDTH-1:0]      pkt_data;
    logic                      pkt_valid;
    logic                      pkt_ready;
    logic                      drop;
    logic [ERRCNT_W-1:0]       err_cnt;

    // master: link sender plus router; slave: the receiver block
    modport master (
        output link_data, link_valid, link_par, pkt_ready,
        input  link_ready, link_err, pkt_data, pkt_valid, drop, err_cnt
    );

    modport slave (
        input  link_data, link_valid, link_par, pkt_ready,
        output link_ready, link_err, pkt_data, pkt_valid, drop, err_cnt
    );
endinterface

// File: rtl/link_sync.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module link_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/chip_link_rx.sv
// Receive side of one off-chip link port: 4-phase beats in, parity checked,
// assembled MSB-first into packets for the router.
module chip_link_rx #(
    parameter int CHIPDATA_WIDTH = pcss_link_pkg::CHIPDATA_WIDTH,
    parameter int PKT_WIDTH      = pcss_link_pkg::PKT_WIDTH,
    parameter int BEATS          = pcss_link_pkg::BEATS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 1024,
    parameter int ERRCNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    chip_link_rx_if.slave  bus
);
    import pcss_link_pkg::*;

    localparam int AW = PKT_WIDTH - CHIPDATA_WIDTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    rx_state_t     state, state_next;
    logic          valid_s, par_ok, buf_free;
    logic          take, last, bad;
    logic          tout, expire;
    logic [AW-1:0] assy;
    logic [BW-1:0] beat_idx;
    logic [TW-1:0] tcnt;

    link_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.link_valid),
        .q   (valid_s)
    );

    assign par_ok   = (^bus.link_data) == bus.link_par;
    assign buf_free = !bus.pkt_valid || bus.pkt_ready;
    assign bus.link_ready = (state == ACK);

    // Idle gap inside a partial packet; the counter only runs while waiting in IDLE
    assign tout   = (TIMEOUT > 0) && (state == IDLE) && (beat_idx != '0) && !valid_s;
    assign expire = tout && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        last       = 1'b0;
        bad        = 1'b0;
        case (state)
            IDLE: begin
                if (valid_s) begin
                    if (!par_ok) begin
                        bad        = 1'b1;
                        state_next = ACK;
                    end else if (beat_idx != LAST) begin
                        take       = 1'b1;
                        state_next = ACK;
                    end else if (buf_free) begin
                        take       = 1'b1;
                        last       = 1'b1;
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (!valid_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.link_err  <= 1'b0;
            bus.err_cnt   <= '0;
            bus.pkt_data  <= '0;
            bus.pkt_valid <= 1'b0;
            bus.drop      <= 1'b0;
            assy          <= '0;
            beat_idx      <= '0;
            tcnt          <= '0;
        end else begin
            bus.drop <= 1'b0;

            if (bad) begin
                bus.link_err <= 1'b1;
                if (bus.err_cnt != '1) begin
                    bus.err_cnt <= bus.err_cnt + 1'b1;
                end
            end else if (state_next == IDLE) begin
                bus.link_err <= 1'b0;
            end

            if (take) begin
                if (last) begin
                    bus.pkt_data <= {assy, bus.link_data};
                    beat_idx     <= '0;
                end else begin
                    assy     <= AW'({assy, bus.link_data});
                    beat_idx <= beat_idx + 1'b1;
                end
            end

            // A load on the same edge as a router accept keeps pkt_valid high
            if (last) begin
                bus.pkt_valid <= 1'b1;
            end else if (bus.pkt_ready) begin
                bus.pkt_valid <= 1'b0;
            end

            if (expire) begin
                beat_idx <= '0;
                assy     <= '0;
                bus.drop <= 1'b1;
                tcnt     <= '0;
            end else if (tout) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_chip_link_rx.sv
// Randomized and directed checking of chip_link_rx against a packet-level model.
module tb_chip_link_rx;
    localparam int SYNC   = 2;
    localparam int TMO    = 16;
    localparam int ERRMAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chip_link_rx_if #(.CHIPDATA_WIDTH(16), .PKT_WIDTH(64), .ERRCNT_W(8)) bus ();

    chip_link_rx #(
        .CHIPDATA_WIDTH (16),
        .PKT_WIDTH      (64),
        .BEATS          (4),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT        (TMO),
        .ERRCNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Packet-level model: beats collected in a queue, packets by shift-and-or
    bit [SYNC-1:0] hist;
    bit            m_ack, m_err, m_pv, m_drop, vs, loaded;
    bit [63:0]     m_pd, pk;
    int            m_errs, idle, cyc;
    bit [15:0]     beats[$];
    bit [63:0]     m_got[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   = '0;
            m_ack  = 0;
            m_err  = 0;
            m_pv   = 0;
            m_pd   = '0;
            m_drop = 0;
            m_errs = 0;
            idle   = 0;
            beats.delete();
        end else begin
            cyc++;
            vs     = hist[SYNC-1];
            hist   = {hist[SYNC-2:0], bus.link_valid};
            m_drop = 0;
            loaded = 0;
            if (m_pv && bus.pkt_ready) m_got.push_back(m_pd);
            if (m_ack) begin
                idle = 0;
                if (!vs) begin
                    m_ack = 0;
                    m_err = 0;
                end
            end else if (vs) begin
                idle = 0;
                if ((^bus.link_data) != bus.link_par) begin
                    m_ack = 1;
                    m_err = 1;
                    if (m_errs < ERRMAX) m_errs++;
                end else if (beats.size() < 3) begin
                    beats.push_back(bus.link_data);
                    m_ack = 1;
                end else if (!m_pv || bus.pkt_ready) begin
                    pk = '0;
                    foreach (beats[i]) pk = (pk << 16) | 64'(beats[i]);
                    pk = (pk << 16) | 64'(bus.link_data);
                    beats.delete();
                    loaded = 1;
                    m_ack  = 1;
                end
            end else if (beats.size() != 0) begin
                idle++;
                if (idle == TMO) begin
                    beats.delete();
                    idle   = 0;
                    m_drop = 1;
                end
            end else begin
                idle = 0;
            end
            if (loaded) begin
                m_pv = 1;
                m_pd = pk;
            end else if (bus.pkt_ready) begin
                m_pv = 0;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int drop_total = 0;
    int pv_total = 0;
    int drop_cyc = 0;
    int fall_cyc = 0;
    bit rand_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("link_ready", 64'(bus.link_ready), 64'(m_ack));
        chk("link_err", 64'(bus.link_err), 64'(m_err));
        chk("pkt_valid", 64'(bus.pkt_valid), 64'(m_pv));
        if (m_pv) chk("pkt_data", bus.pkt_data, m_pd);
        chk("drop", 64'(bus.drop), 64'(m_drop));
        chk("err_cnt", 64'(bus.err_cnt), 64'(m_errs));
        if (bus.link_err) chk("err_needs_ready", 64'(bus.link_ready), 64'd1);
        if (bus.drop) begin
            drop_total++;
            drop_cyc = cyc;
        end
        if (bus.pkt_valid) pv_total++;
        if (rand_mode) bus.pkt_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic raise_beat(input logic [15:0] d, input bit badpar);
        bus.link_data  = d;
        bus.link_par   = (^d) ^ badpar;
        bus.link_valid = 1'b1;
    endtask

    task automatic finish_beat(output bit err);
        int n;
        n = 0;
        while (!bus.link_ready && n < 200) begin
            tick();
            n++;
        end
        chk("ack_seen", 64'(bus.link_ready), 64'd1);
        err = bus.link_err;
        bus.link_valid = 1'b0;
        n = 0;
        while (bus.link_ready && n < 200) begin
            tick();
            n++;
        end
        chk("ack_released", 64'(bus.link_ready), 64'd0);
        fall_cyc = cyc;
        tick();
    endtask

    task automatic send_beat(input logic [15:0] d, input bit badpar, output bit err);
        raise_beat(d, badpar);
        finish_beat(err);
    endtask

    task automatic send_pkt(input logic [63:0] p, output bit err_any);
        bit e;
        logic [63:0] v;
        v = p;
        err_any = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            send_beat(v[63:48], 1'b0, e);
            err_any |= e;
            v = v << 16;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit e, ea;
        int base, pv0, d0;
        logic [15:0] d;
        bus.link_data  = '0;
        bus.link_par   = 1'b0;
        bus.link_valid = 1'b0;
        bus.pkt_ready  = 1'b1;
        repeat (3) tick();
        chk("reset_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        chk("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic packet
        base = m_got.size();
        pv0  = pv_total;
        send_pkt(64'h0123_4567_89AB_CDEF, ea);
        repeat (3) tick();
        chk("t1_link_err_seen", 64'(ea), 64'd0);
        chk("t1_pv_cycles", 64'(pv_total - pv0), 64'd1);
        chk("t1_err_cnt", 64'(bus.err_cnt), 64'd0);
        chk("t1_count", 64'(m_got.size() - base), 64'd1);
        chk("t1_pkt", m_got[base], 64'h0123_4567_89AB_CDEF);
        chk("t1_pkt_hold", bus.pkt_data, 64'h0123_4567_89AB_CDEF);

        // Parity error then resend
        base = m_got.size();
        send_beat(16'h0123, 1'b0, e);
        send_beat(16'h4567, 1'b1, e);
        chk("t2_bad_err_flag", 64'(e), 64'd1);
        chk("t2_err_cnt", 64'(bus.err_cnt), 64'd1);
        send_beat(16'h4567, 1'b0, e);
        chk("t2_good_err_flag", 64'(e), 64'd0);
        send_beat(16'h89AB, 1'b0, e);
        send_beat(16'hCDEF, 1'b0, e);
        repeat (3) tick();
        chk("t2_pkt", m_got[base], 64'h0123_4567_89AB_CDEF);

        // Back-pressure: second packet's last beat stalls
        base = m_got.size();
        bus.pkt_ready = 1'b0;
        send_pkt(64'h1111_1111_1111_1111, ea);
        for (int unsigned i = 0; i < 3; i++) send_beat(16'h2222, 1'b0, e);
        raise_beat(16'h2222, 1'b0);
        repeat (20) tick();
        chk("t3_stall_no_ack", 64'(bus.link_ready), 64'd0);
        chk("t3_held_data", bus.pkt_data, 64'h1111_1111_1111_1111);
        bus.pkt_ready = 1'b1;
        finish_beat(e);
        repeat (3) tick();
        chk("t3_count", 64'(m_got.size() - base), 64'd2);
        chk("t3_first", m_got[base], 64'h1111_1111_1111_1111);
        chk("t3_second", m_got[base+1], 64'h2222_2222_2222_2222);

        // Timeout after two beats
        d0 = drop_total;
        send_beat(16'h1234, 1'b0, e);
        send_beat(16'h5678, 1'b0, e);
        repeat (20) tick();
        chk("t4_drop_count", 64'(drop_total - d0), 64'd1);
        chk("t4_drop_delay", 64'(drop_cyc - fall_cyc), 64'd16);
        base = m_got.size();
        send_pkt(64'hAAAA_BBBB_CCCC_DDDD, ea);
        repeat (3) tick();
        chk("t4_pkt", m_got[base], 64'hAAAA_BBBB_CCCC_DDDD);

        // Random beats, parity errors, gaps and router back-pressure
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            d = 16'($urandom);
            send_beat(d, ($urandom_range(0, 9) == 0), e);
            repeat (($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3)) tick();
        end
        rand_mode = 0;
        bus.pkt_ready = 1'b1;
        repeat (5) tick();

        // Asynchronous reset mid-packet with a pending packet
        send_beat(16'h0F0F, 1'b1, e);
        bus.pkt_ready = 1'b0;
        send_pkt(64'h5555_5555_5555_5555, ea);
        send_beat(16'h1357, 1'b0, e);
        send_beat(16'h2468, 1'b0, e);
        chk("t5_pending", 64'(bus.pkt_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        chk("t5_rst_pkt_data", bus.pkt_data, 64'd0);
        chk("t5_rst_link_ready", 64'(bus.link_ready), 64'd0);
        chk("t5_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        chk("t5_rst_drop", 64'(bus.drop), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        bus.pkt_ready = 1'b1;
        tick();
        base = m_got.size();
        send_pkt(64'hDEAD_BEEF_0000_FFFF, ea);
        repeat (3) tick();
        chk("t5_count", 64'(m_got.size() - base), 64'd1);
        chk("t5_pkt", m_got[base], 64'hDEAD_BEEF_0000_FFFF);
        chk("t5_pkt_dut", bus.pkt_data, 64'hDEAD_BEEF_0000_FFFF);

        // Error counter saturation
        base = m_got.size();
        pv0  = pv_total;
        for (int unsigned i = 0; i < 300; i++) begin
            d = 16'($urandom);
            send_beat(d, 1'b1, e);
        end
        repeat (3) tick();
        chk("t6_err_sat", 64'(bus.err_cnt), 64'd255);
        chk("t6_no_pkts", 64'(m_got.size() - base), 64'd0);
        chk("t6_no_pv", 64'(pv_total - pv0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/chip_link_rx.md
Name: chip_link_rx

Overview:
- Receive side of one off-chip 16-bit link port (E/N/W/S), inside the chip top.
- Accepts beats on a 4-phase valid/ready handshake and checks even parity per beat.
- Assembles 4 beats, MSB first, into one 64-bit packet (FW+CONNECT_WIDTH) and hands it to the on-chip router on a valid/ready interface.
- One instance per port.

Parameters:
- CHIPDATA_WIDTH, 16: link beat width.
- PKT_WIDTH, 64: assembled packet width; must equal BEATS*CHIPDATA_WIDTH.
- BEATS, 4: beats per packet.
- SYNC_STAGES, 2: flops synchronising link_valid; minimum 2.
- TIMEOUT, 1024: idle cycles allowed between beats of one packet; 0 disables the timeout.
- ERRCNT_W, 8: width of the saturating parity-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- link_data  in  CHIPDATA_WIDTH  beat data; stable while link_valid is high.
- link_valid  in  1  beat request (4-phase); asynchronous to clk.
- link_par  in  1  even parity of link_data.
- link_ready  out  1  beat acknowledge.
- link_err  out  1  parity-error flag, valid only while link_ready=1.
- pkt_data  out  PKT_WIDTH  assembled packet; beat 0 in the MSBs.
- pkt_valid  out  1  packet available.
- pkt_ready  in  1  router accepts the packet.
- drop  out  1  one-cycle pulse when a partial packet is discarded on timeout.
- err_cnt  out  ERRCNT_W  count of parity errors, saturating.

Behaviour:
- Reset: all outputs 0, beat_idx=0, state IDLE, timeout counter 0, synchroniser flops 0.
- valid_s is link_valid after SYNC_STAGES flops. link_data and link_par are sampled directly; they are stable by the handshake.
- Parity check: ok when ^link_data == link_par.
- Output buffer free: !pkt_valid || pkt_ready.
- FSM, IDLE (link_ready=0) on valid_s=1:
  - Parity bad: link_ready<=1, link_err<=1, err_cnt += 1 (saturates at all-ones), beat not stored, beat_idx unchanged, go to ACK. The sender re-sends the same beat.
  - Parity ok, beat_idx<BEATS-1: shift the beat into the assembly register, beat_idx+=1, link_ready<=1, go to ACK.
  - Parity ok, beat_idx==BEATS-1, buffer free: on the same edge pkt_data<={assembly, link_data}, pkt_valid<=1, beat_idx<=0, link_ready<=1, go to ACK.
  - Parity ok, beat_idx==BEATS-1, buffer not free: stall in IDLE with link_ready=0; the beat is accepted on the first cycle the buffer is free.
- FSM, ACK (link_ready=1): on valid_s=0, link_ready<=0, link_err<=0, go to IDLE.
- Latency: link_ready rises 1 cycle after valid_s rises (SYNC_STAGES+1 clk after link_valid). pkt_valid rises on the same edge as the last beat's link_ready.
- Packet output:
  - pkt_valid clears on the edge where pkt_valid && pkt_ready, unless a new packet is loaded on that same edge; then pkt_valid stays 1 with the new data.
  - pkt_data is held stable while pkt_valid && !pkt_ready.
- Timeout (TIMEOUT>0):
  - The counter increments in IDLE while beat_idx!=0 and valid_s=0, and clears otherwise.
  - On reaching TIMEOUT: beat_idx<=0, assembly register discarded, drop=1 for one cycle, counter cleared.
  - The timeout counter never runs in ACK.
- Reset mid-packet: the partial packet and the pending pkt_valid are lost. After reset release, the first beat seen is treated as beat 0.
- link_err never asserts without link_ready.

Decomposition:
- Shared package pcss_link_pkg holds CHIPDATA_WIDTH, PKT_WIDTH, BEATS, and the rx FSM state enum {IDLE, ACK}. The tx serializer reuses the same package.
- Sub-module: link_sync, a SYNC_STAGES-flop synchroniser with asynchronous active-high reset, also reused by tx for its ready input.

Test Plan:
- Four beats 0x0123, 0x4567, 0x89AB, 0xCDEF with correct parity, pkt_ready=1 → pkt_data=0x0123456789ABCDEF, pkt_valid high 1 cycle, 4 link_ready pulses, link_err never 1, err_cnt=0.
- Beat 2 (0x4567) sent with inverted parity, then re-sent correctly → first ack has link_err=1, err_cnt=1; packet output still 0x0123456789ABCDEF.
- pkt_ready=0 while two packets 0x1111…1111 and 0x2222…2222 are sent → first held on pkt_data; beat 3 of the second gets no link_ready until pkt_ready=1; output order 0x1111… then 0x2222…, nothing lost.
- TIMEOUT=16: send 2 beats, then idle 20 cycles → drop pulses exactly 16 cycles after the second handshake completes; next full packet 0xAAAA_BBBB_CCCC_DDDD is assembled correctly.
- rst asserted after beat 2 → all outputs 0 immediately (asynchronous); after release, packet 0xDEAD_BEEF_0000_FFFF is received intact.
- 300 consecutive bad-parity beats → err_cnt saturates at 255, no pkt_valid.
